// File: rtl/video_pkg.sv
// ============================================================================
//  Module      : video_pkg
//  Description : Default raster timing, config addresses and compare types
//                shared by the raster generator and its interrupt channels.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package video_pkg;

    localparam int C_H_TOTAL        = 384;
    localparam int C_V_TOTAL        = 312;
    localparam int C_H_BLANK_START  = 24;
    localparam int C_H_SYNC_START   = 40;
    localparam int C_H_SYNC_END     = 72;
    localparam int C_H_BLANK_END    = 104;
    localparam int C_V_BLANK_START  = 240;
    localparam int C_V_SYNC_START   = 244;
    localparam int C_V_SYNC_END     = 248;
    localparam int C_V_BLANK_END    = 264;
    localparam int C_H_ACTIVE_START = 128;
    localparam int C_ACTIVE_LINES   = 192;
    localparam int C_FETCH_LEAD     = 8;
    localparam int C_INT_LEN        = 128;
    localparam int C_NCMP           = 2;
    localparam int C_FLASH_W        = 5;
    localparam int C_HC_W           = 9;
    localparam int C_VC_W           = 9;

    localparam logic [3:0] CFG_PEND_CLR = 4'd15;

    localparam int C_CMP_W = 8;
    typedef logic [C_CMP_W-1:0] cmp_t;
    typedef cmp_t [C_NCMP-1:0]  cmp_arr_t;

    // 8'hFF is beyond any paper line, so a fresh channel never fires.
    localparam cmp_t C_CMP_RESET = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/video_int_ch.sv
// ============================================================================
//  Module      : video_int_ch
//  Description : One line-interrupt channel: compare register, registered
//                interrupt level and sticky pending bit. FIXED=1 turns it
//                into the frame channel with a hard-wired line.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_int_ch
    import video_pkg::*;
#(
    parameter int HC_W         = 9,
    parameter int VC_W         = 9,
    parameter int ACTIVE_LINES = 192,
    parameter int INT_LEN      = 128,
    parameter bit FIXED        = 1'b0,
    parameter int FIXED_LINE   = 0
) (
    input  logic            clk_sys,
    input  logic            nRESET,
    input  logic            ce_pix,
    input  logic [HC_W-1:0] hc_i,
    input  logic [VC_W-1:0] vc_i,
    input  logic            cmp_we_i,
    input  cmp_t            cmp_data_i,
    input  logic            pend_clr_i,
    output logic            int_o,
    output logic            pend_o
);

    cmp_t            cmp_q;
    logic            int_q;
    logic            pend_q;
    logic [VC_W-1:0] w_line;
    logic            w_line_ok;
    logic            w_int_d;

    // The compare register is loaded on any clk_sys; the ce logic below
    // only sees the new value from the following ce onward.
    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            cmp_q <= C_CMP_RESET;
        end else if (cmp_we_i && !FIXED) begin
            cmp_q <= cmp_data_i;
        end
    end

    assign w_line    = FIXED ? VC_W'(FIXED_LINE) : VC_W'(cmp_q);
    assign w_line_ok = FIXED || (32'(cmp_q) < 32'(ACTIVE_LINES));
    assign w_int_d   = w_line_ok && (vc_i == w_line) && (32'(hc_i) < 32'(INT_LEN));

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            int_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            if (ce_pix) begin
                int_q <= w_int_d;
            end
            // Set beats clear when both land in the same clk.
            pend_q <= (ce_pix && w_int_d && !int_q) || (pend_q && !pend_clr_i);
        end
    end

    assign int_o  = int_q;
    assign pend_o = pend_q;

endmodule

`default_nettype wire

// File: rtl/video_raster_gen.sv
// ============================================================================
//  Module      : video_raster_gen
//  Description : Parametrised raster timing generator with line/frame
//                interrupts, flash counter and optional light-pen latch
//                (enabled by defining VIDEO_LPEN_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_raster_gen
    import video_pkg::*;
#(
    parameter int H_TOTAL        = C_H_TOTAL,
    parameter int V_TOTAL        = C_V_TOTAL,
    parameter int H_BLANK_START  = C_H_BLANK_START,
    parameter int H_SYNC_START   = C_H_SYNC_START,
    parameter int H_SYNC_END     = C_H_SYNC_END,
    parameter int H_BLANK_END    = C_H_BLANK_END,
    parameter int V_BLANK_START  = C_V_BLANK_START,
    parameter int V_SYNC_START   = C_V_SYNC_START,
    parameter int V_SYNC_END     = C_V_SYNC_END,
    parameter int V_BLANK_END    = C_V_BLANK_END,
    parameter int H_ACTIVE_START = C_H_ACTIVE_START,
    parameter int ACTIVE_LINES   = C_ACTIVE_LINES,
    parameter int FETCH_LEAD     = C_FETCH_LEAD,
    parameter int INT_LEN        = C_INT_LEN,
    parameter int NCMP           = C_NCMP,
    parameter int FLASH_W        = C_FLASH_W,
    parameter int HC_W           = C_HC_W,
    parameter int VC_W           = C_VC_W
) (
    input  logic            clk_sys,
    input  logic            nRESET,
    input  logic            ce_pix,
    input  logic            cfg_we,
    input  logic [3:0]      cfg_addr,
    input  logic [7:0]      cfg_data,
    output logic [HC_W-1:0] hc,
    output logic [VC_W-1:0] vc,
    output logic            hblank,
    output logic            vblank,
    output logic            hsync,
    output logic            vsync,
    output logic            de,
    output logic            fetch,
    output logic [NCMP-1:0] int_line,
    output logic            int_frame,
    output logic [NCMP:0]   int_pend,
    output logic            flash,
    input  logic            lpen_strobe,
    output logic [7:0]      lpen_x,
    output logic [7:0]      lpen_y
);

    localparam logic [HC_W-1:0] c_h_last      = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0] c_v_last      = VC_W'(V_TOTAL - 1);
    localparam logic [HC_W-1:0] c_hbs         = HC_W'(H_BLANK_START);
    localparam logic [HC_W-1:0] c_hbe         = HC_W'(H_BLANK_END);
    localparam logic [HC_W-1:0] c_hss         = HC_W'(H_SYNC_START);
    localparam logic [HC_W-1:0] c_hse         = HC_W'(H_SYNC_END);
    localparam logic [VC_W-1:0] c_vbs         = VC_W'(V_BLANK_START);
    localparam logic [VC_W-1:0] c_vbe         = VC_W'(V_BLANK_END);
    localparam logic [VC_W-1:0] c_vss         = VC_W'(V_SYNC_START);
    localparam logic [VC_W-1:0] c_vse         = VC_W'(V_SYNC_END);
    localparam logic [HC_W-1:0] c_has         = HC_W'(H_ACTIVE_START);
    localparam logic [HC_W-1:0] c_fetch_start = HC_W'(H_ACTIVE_START - FETCH_LEAD);
    localparam logic [VC_W-1:0] c_al          = VC_W'(ACTIVE_LINES);

    logic [HC_W-1:0]    hc_q, hc_d;
    logic [VC_W-1:0]    vc_q, vc_d;
    logic [FLASH_W-1:0] flash_q, flash_d;
    logic               hblank_q, vblank_q, hsync_q, vsync_q, de_q, fetch_q;
    logic               w_paper_line;

    assign w_paper_line = (vc_q < c_al);

    always_comb begin
        hc_d    = hc_q + HC_W'(1);
        vc_d    = vc_q;
        flash_d = flash_q;
        if (hc_q == c_h_last) begin
            hc_d = '0;
            if (vc_q == c_v_last) begin
                vc_d    = '0;
                flash_d = flash_q + FLASH_W'(1);
            end else begin
                vc_d = vc_q + VC_W'(1);
            end
        end
    end

    // Window flags are decoded from the pre-increment counters, so each
    // edge shows up one ce after its compare point.
    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            hc_q     <= '0;
            vc_q     <= '0;
            flash_q  <= '0;
            hblank_q <= 1'b0;
            vblank_q <= 1'b0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            de_q     <= 1'b0;
            fetch_q  <= 1'b0;
        end else if (ce_pix) begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            flash_q <= flash_d;
            if (hc_q == c_hbs) begin
                hblank_q <= 1'b1;
            end else if (hc_q == c_hbe) begin
                hblank_q <= 1'b0;
            end
            if (hc_q == c_hss) begin
                hsync_q <= 1'b1;
            end else if (hc_q == c_hse) begin
                hsync_q <= 1'b0;
            end
            if ((vc_q == c_vbs) && (hc_q == c_hbs)) begin
                vblank_q <= 1'b1;
            end else if ((vc_q == c_vbe) && (hc_q == c_hbe)) begin
                vblank_q <= 1'b0;
            end
            vsync_q <= (vc_q >= c_vss) && (vc_q < c_vse);
            de_q    <= w_paper_line && (hc_q >= c_has);
            fetch_q <= (hc_q[2:0] == 3'd0) && (hc_q >= c_fetch_start) && w_paper_line;
        end
    end

    assign hc     = hc_q;
    assign vc     = vc_q;
    assign hblank = hblank_q;
    assign vblank = vblank_q;
    assign hsync  = hsync_q;
    assign vsync  = vsync_q;
    assign de     = de_q;
    assign fetch  = fetch_q;
    assign flash  = flash_q[FLASH_W-1];

    logic            w_pend_clr;
    logic            w_frame_clr;
    logic [NCMP-1:0] w_cmp_we;
    logic [NCMP-1:0] w_line_clr;

    assign w_pend_clr = cfg_we && (cfg_addr == CFG_PEND_CLR);

    for (genvar gi = 0; gi < NCMP; gi++) begin : g_line
        assign w_cmp_we[gi]   = cfg_we && (cfg_addr == 4'(gi));
        assign w_line_clr[gi] = w_pend_clr && cfg_data[gi];

        video_int_ch #(
            .HC_W         (HC_W),
            .VC_W         (VC_W),
            .ACTIVE_LINES (ACTIVE_LINES),
            .INT_LEN      (INT_LEN),
            .FIXED        (1'b0),
            .FIXED_LINE   (0)
        ) u_ch (
            .clk_sys    (clk_sys),
            .nRESET     (nRESET),
            .ce_pix     (ce_pix),
            .hc_i       (hc_q),
            .vc_i       (vc_q),
            .cmp_we_i   (w_cmp_we[gi]),
            .cmp_data_i (cfg_data),
            .pend_clr_i (w_line_clr[gi]),
            .int_o      (int_line[gi]),
            .pend_o     (int_pend[gi])
        );
    end

    // With eight line channels the frame bit has no clear bit in cfg_data.
    if (NCMP < 8) begin : g_fclr_bit
        assign w_frame_clr = w_pend_clr && cfg_data[NCMP];
    end else begin : g_fclr_none
        assign w_frame_clr = 1'b0;
    end

    video_int_ch #(
        .HC_W         (HC_W),
        .VC_W         (VC_W),
        .ACTIVE_LINES (ACTIVE_LINES),
        .INT_LEN      (INT_LEN),
        .FIXED        (1'b1),
        .FIXED_LINE   (V_SYNC_START)
    ) u_frame (
        .clk_sys    (clk_sys),
        .nRESET     (nRESET),
        .ce_pix     (ce_pix),
        .hc_i       (hc_q),
        .vc_i       (vc_q),
        .cmp_we_i   (1'b0),
        .cmp_data_i ('0),
        .pend_clr_i (w_frame_clr),
        .int_o      (int_frame),
        .pend_o     (int_pend[NCMP])
    );

`ifdef VIDEO_LPEN_EN
    logic [2:0] lpen_sync_q;
    logic [7:0] lpen_x_q, lpen_y_q;

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            lpen_sync_q <= '0;
            lpen_x_q    <= '0;
            lpen_y_q    <= '0;
        end else begin
            lpen_sync_q <= {lpen_sync_q[1:0], lpen_strobe};
            if (lpen_sync_q[1] && !lpen_sync_q[2]) begin
                lpen_x_q <= de_q ? {~hc_q[7], hc_q[6:0]} : 8'h00;
                lpen_y_q <= (vc_q >= c_al) ? 8'(ACTIVE_LINES) : 8'(vc_q);
            end
        end
    end

    assign lpen_x = lpen_x_q;
    assign lpen_y = lpen_y_q;
`else
    logic w_lpen_unused;
    assign w_lpen_unused = lpen_strobe;
    assign lpen_x        = 8'h00;
    assign lpen_y        = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_video_raster_gen.sv
// ============================================================================
//  Module      : tb_video_raster_gen
//  Description : Scoreboard bench for video_raster_gen on a reduced raster
//                (48x40) so many frames fit in a short run.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_video_raster_gen;

    localparam int HT  = 48;
    localparam int VT  = 40;
    localparam int HBS = 3;
    localparam int HSS = 5;
    localparam int HSE = 9;
    localparam int HBE = 13;
    localparam int VBS = 30;
    localparam int VSS = 31;
    localparam int VSE = 32;
    localparam int VBE = 33;
    localparam int HAS = 16;
    localparam int AL  = 24;
    localparam int FL  = 8;
    localparam int IL  = 16;
    localparam int NCMP = 2;
    localparam int FW  = 2;

    logic            clk_sys = 1'b0;
    logic            nRESET;
    logic            ce_pix;
    logic            cfg_we;
    logic [3:0]      cfg_addr;
    logic [7:0]      cfg_data;
    logic [8:0]      hc, vc;
    logic            hblank, vblank, hsync, vsync, de, fetch;
    logic [NCMP-1:0] int_line;
    logic            int_frame;
    logic [NCMP:0]   int_pend;
    logic            flash;
    logic            lpen_strobe;
    logic [7:0]      lpen_x, lpen_y;

    video_raster_gen #(
        .H_TOTAL (HT), .V_TOTAL (VT),
        .H_BLANK_START (HBS), .H_SYNC_START (HSS), .H_SYNC_END (HSE), .H_BLANK_END (HBE),
        .V_BLANK_START (VBS), .V_SYNC_START (VSS), .V_SYNC_END (VSE), .V_BLANK_END (VBE),
        .H_ACTIVE_START (HAS), .ACTIVE_LINES (AL), .FETCH_LEAD (FL), .INT_LEN (IL),
        .NCMP (NCMP), .FLASH_W (FW), .HC_W (9), .VC_W (9)
    ) dut (
        .clk_sys (clk_sys), .nRESET (nRESET), .ce_pix (ce_pix),
        .cfg_we (cfg_we), .cfg_addr (cfg_addr), .cfg_data (cfg_data),
        .hc (hc), .vc (vc), .hblank (hblank), .vblank (vblank),
        .hsync (hsync), .vsync (vsync), .de (de), .fetch (fetch),
        .int_line (int_line), .int_frame (int_frame), .int_pend (int_pend),
        .flash (flash), .lpen_strobe (lpen_strobe),
        .lpen_x (lpen_x), .lpen_y (lpen_y)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [8:0]      hc;
        logic [8:0]      vc;
        logic            hblank, vblank, hsync, vsync, de, fetch;
        logic [NCMP-1:0] il;
        logic            fr;
        logic [NCMP:0]   pend;
        logic            flash;
        logic [7:0]      lx;
        logic [7:0]      ly;
    } exp_t;

    exp_t cur;
    exp_t sb[$];
    int   m_cmp[NCMP];
    int   m_flash;
`ifdef VIDEO_LPEN_EN
    logic [2:0] m_sync;
`endif

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [$bits(exp_t)-1:0] dut_vec();
        return {hc, vc, hblank, vblank, hsync, vsync, de, fetch,
                int_line, int_frame, int_pend, flash, lpen_x, lpen_y};
    endfunction

    task automatic model_reset();
        cur = '0;
        for (int i = 0; i < NCMP; i++) m_cmp[i] = 255;
        m_flash = 0;
`ifdef VIDEO_LPEN_EN
        m_sync = '0;
`endif
    endtask

    // Windows are expressed as ranges over the pre-increment position.
    task automatic model_step(input bit ce, input bit we, input logic [3:0] addr, input logic [7:0] data);
        exp_t          nx;
        int            h, v, pos;
        logic [NCMP:0] set, clr;
        nx  = cur;
        h   = int'(cur.hc);
        v   = int'(cur.vc);
        pos = v * HT + h;
        set = '0;
        if (ce) begin
            nx.hblank = (h >= HBS) && (h < HBE);
            nx.hsync  = (h >= HSS) && (h < HSE);
            nx.vblank = (pos >= VBS * HT + HBS) && (pos < VBE * HT + HBE);
            nx.vsync  = (v >= VSS) && (v < VSE);
            nx.de     = (v < AL) && (h >= HAS);
            nx.fetch  = (h % 8 == 0) && (h >= HAS - FL) && (v < AL);
            for (int i = 0; i < NCMP; i++)
                nx.il[i] = (m_cmp[i] < AL) && (v == m_cmp[i]) && (h < IL);
            nx.fr = (v == VSS) && (h < IL);
            set   = {nx.fr, nx.il} & ~{cur.fr, cur.il};
            if (h == HT - 1) begin
                nx.hc = '0;
                if (v == VT - 1) begin
                    nx.vc   = '0;
                    m_flash = (m_flash + 1) % (1 << FW);
                end else begin
                    nx.vc = 9'(v + 1);
                end
            end else begin
                nx.hc = 9'(h + 1);
            end
            nx.flash = ((m_flash >> (FW - 1)) & 1) != 0;
        end
        clr     = (we && addr == 4'd15) ? data[NCMP:0] : '0;
        nx.pend = set | (cur.pend & ~clr);
        if (we && int'(addr) < NCMP) m_cmp[addr] = int'(data);
`ifdef VIDEO_LPEN_EN
        if (m_sync[1] && !m_sync[2]) begin
            nx.lx = cur.de ? {~cur.hc[7], cur.hc[6:0]} : 8'h00;
            nx.ly = (int'(cur.vc) >= AL) ? 8'(AL) : cur.vc[7:0];
        end
        m_sync = {m_sync[1:0], lpen_strobe};
`endif
        cur = nx;
    endtask

    task automatic step(input bit ce, input bit we, input logic [3:0] addr, input logic [7:0] data);
        exp_t e;
        ce_pix   = ce;
        cfg_we   = we;
        cfg_addr = addr;
        cfg_data = data;
        model_step(ce, we, addr, data);
        sb.push_back(cur);
        @(posedge clk_sys);
        #1;
        e = sb.pop_front();
        check("outs", 64'(dut_vec()), 64'(e));
        cfg_we = 1'b0;
    endtask

    task automatic seek(input int tv, input int th);
        int guard;
        guard = 0;
        while (!(int'(cur.vc) == tv && int'(cur.hc) == th) && guard < 20000) begin
            step($urandom_range(3) != 0, 1'b0, 4'd0, 8'd0);
            guard++;
        end
        check("seek", 64'({vc, hc}), 64'({9'(tv), 9'(th)}));
    endtask

    task automatic lpen_pulse();
        lpen_strobe = 1'b1;
        repeat (4) step($urandom_range(3) != 0, 1'b0, 4'd0, 8'd0);
        lpen_strobe = 1'b0;
        repeat (4) step($urandom_range(3) != 0, 1'b0, 4'd0, 8'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ce, we, wrap;
        bit clr0_done, clr2_done, race_done, mid_done;
        logic [3:0] addr;
        logic [7:0] data;
        int frames, cnt0, cnt1, guard;

        nRESET = 1'b0; ce_pix = 1'b0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_data = '0; lpen_strobe = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_sys);
        #1;
        check("reset", 64'(dut_vec()), 64'(0));
        nRESET = 1'b1;

        step(1'b1, 1'b1, 4'd0, 8'd10);
        step(1'b0, 1'b1, 4'd1, 8'd30);
        step(1'b1, 1'b1, 4'd5, 8'd3);

        frames = 0; cnt0 = 0; cnt1 = 0; guard = 0;
        clr0_done = 0; clr2_done = 0; race_done = 0; mid_done = 0;
        while (frames < 9 && guard < 40000) begin
            guard++;
            ce = ($urandom_range(3) != 0);
            we = 1'b0; addr = 4'd0; data = 8'd0;
            if (frames == 0 && cur.vc == 9'd12 && !clr0_done) begin
                check("pend0_set", 64'(int_pend[0]), 64'(1));
                we = 1'b1; addr = 4'd15; data = 8'h01;
            end else if (frames == 1 && cur.vc == 9'd5 && !clr2_done) begin
                check("pendf_set", 64'(int_pend[NCMP]), 64'(1));
                we = 1'b1; addr = 4'd15; data = 8'h04;
            end else if (frames == 1 && cur.vc == 9'(VSS) && cur.hc == 9'd0 && !race_done) begin
                ce = 1'b1; we = 1'b1; addr = 4'd15; data = 8'h04;
            end else if (frames == 2 && cur.vc == 9'd12 && cur.hc == 9'd5 && !mid_done) begin
                we = 1'b1; addr = 4'd0; data = 8'd12;
                mid_done = 1;
            end
            wrap = ce && (int'(cur.hc) == HT - 1) && (int'(cur.vc) == VT - 1);
            step(ce, we, addr, data);
            if (we && addr == 4'd15 && data == 8'h01 && !clr0_done) begin
                check("pend0_clr", 64'(int_pend[0]), 64'(0));
                clr0_done = 1;
            end else if (we && addr == 4'd15 && frames == 1 && !clr2_done) begin
                check("pendf_clr", 64'(int_pend[NCMP]), 64'(0));
                clr2_done = 1;
            end else if (we && addr == 4'd15 && frames == 1 && !race_done) begin
                check("race_pend", 64'(int_pend[NCMP]), 64'(1));
                race_done = 1;
            end
            if (ce && frames == 0) cnt0 += int'(int_line[0]);
            if (ce) cnt1 += int'(int_line[1]);
            if (wrap) begin
                check("wrap", 64'({hc, vc}), 64'(0));
                frames++;
                check("flash", 64'(flash), 64'((frames % 4) >= 2));
            end
        end
        check("frames", 64'(frames), 64'(9));
        check("int0_len", 64'(cnt0), 64'(IL));
        check("int1_none", 64'(cnt1), 64'(0));

        seek(15, 20);
        nRESET = 1'b0;
        #1;
        check("async_rst", 64'(dut_vec()), 64'(0));
        model_reset();
        ce_pix = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
        check("rst_hold", 64'(dut_vec()), 64'(0));
        nRESET = 1'b1;
        step(1'b1, 1'b0, 4'd0, 8'd0);
        check("restart", 64'({vc, hc}), 64'({9'd0, 9'd1}));

        seek(5, 20);
        lpen_pulse();
`ifdef VIDEO_LPEN_EN
        check("lpen_y_paper", 64'(lpen_y), 64'(5));
        check("lpen_x_msb", 64'(lpen_x[7]), 64'(1));
        check("lpen_x_paper", 64'(lpen_x), 64'(cur.lx));
`else
        check("lpen_y_paper", 64'(lpen_y), 64'(0));
        check("lpen_x_paper", 64'(lpen_x), 64'(0));
`endif
        seek(VBS, 20);
        lpen_pulse();
`ifdef VIDEO_LPEN_EN
        check("lpen_y_blank", 64'(lpen_y), 64'(AL));
`else
        check("lpen_y_blank", 64'(lpen_y), 64'(0));
`endif
        check("lpen_x_blank", 64'(lpen_x), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/video_raster_gen.md
Name: video_raster_gen

Overview:
- Parametrised raster timing generator, successor to the fixed 384x312 Sam Coupe counter logic.
- Produces pixel/line counters, blank/sync windows, active-display flag and fetch strobes.
- Adds NCMP programmable line-interrupt channels with sticky pending bits, a frame interrupt and a flash counter.
- Sits between the clock-enable generator and the pixel fetch/palette path.

Parameters:
- H_TOTAL, 384: pixel clocks per line.
- V_TOTAL, 312: lines per frame.
- H_BLANK_START / H_SYNC_START / H_SYNC_END / H_BLANK_END, 24/40/72/104: hc compare points.
- V_BLANK_START / V_SYNC_START / V_SYNC_END / V_BLANK_END, 240/244/248/264: vc compare points.
- H_ACTIVE_START, 128: first hc of the paper area.
- ACTIVE_LINES, 192: paper lines, starting at vc=0.
- FETCH_LEAD, 8: fetch strobes begin this many hc before H_ACTIVE_START.
- INT_LEN, 128: interrupt assertion length in ce_pix, starting at hc=0.
- NCMP, 2: number of line-compare channels (1..8).
- FLASH_W, 5: flash counter width.
- HC_W / VC_W, 9/9: counter widths.

Ports:
- clk_sys, in, 1: master clock.
- nRESET, in, 1: asynchronous active-low reset.
- ce_pix, in, 1: pixel clock enable.
- cfg_we, in, 1: config write strobe, one clk_sys.
- cfg_addr, in, 4: 0..NCMP-1 selects a compare register; 15 selects pending-clear.
- cfg_data, in, 8: write data.
- hc, out, HC_W: horizontal counter.
- vc, out, VC_W: vertical counter.
- hblank / vblank / hsync / vsync, out, 1 each: timing windows.
- de, out, 1: paper area active.
- fetch, out, 1: one-ce_pix strobe per 8-pixel group.
- int_line, out, NCMP: per-channel line interrupt level.
- int_frame, out, 1: frame interrupt level.
- int_pend, out, NCMP+1: sticky pending bits; bit NCMP is frame.
- flash, out, 1: MSB of the flash counter.
- lpen_strobe, in, 1: light-pen trigger.
- lpen_x / lpen_y, out, 8 each: light-pen latch.

Behaviour:
- Reset (nRESET low, async): hc=0, vc=0, all window flags 0, de=0, fetch=0, int_*=0, int_pend=0, flash counter=0, compare registers=8'hFF, lpen_x=lpen_y=0.
- All state changes on clk_sys only in cycles where ce_pix=1. The only exceptions are cfg writes and lpen sampling, which act on any clk_sys.
- hc: increments; at H_TOTAL-1 it wraps to 0 and vc advances. vc wraps from V_TOTAL-1 to 0, and on that wrap the flash counter increments and wraps mod 2^FLASH_W.
- Window flags: registered. A flag set at point P becomes visible the clk after the ce where the pre-increment hc==P, i.e. one ce of lag.
  - hblank: set at H_BLANK_START, cleared at H_BLANK_END.
  - hsync: set at H_SYNC_START, cleared at H_SYNC_END.
  - vblank: set when vc==V_BLANK_START and hc==H_BLANK_START; cleared when vc==V_BLANK_END and hc==H_BLANK_END.
  - vsync: high for V_SYNC_START<=vc<V_SYNC_END.
- de: registered (vc<ACTIVE_LINES) & (hc>=H_ACTIVE_START).
- fetch: registered, high for one ce when hc[2:0]==0 & hc>=H_ACTIVE_START-FETCH_LEAD & vc<ACTIVE_LINES.
- int_line[i]: registered (cmp[i]<ACTIVE_LINES) & (vc==cmp[i]) & (hc<INT_LEN).
- int_frame: registered (vc==V_SYNC_START) & (hc<INT_LEN).
- int_pend: a bit sets on the rising edge of its int level. Writing address 15 clears the bits where cfg_data has a 1. If set and clear land in the same clk, set wins.
- Compare write: takes effect at the next ce. Writing a value equal to the current vc mid-window asserts int_line for the rest of the window.
- Writes to an unimplemented address are ignored.
- Any cfg_we pulse counts once; there is no edge detection inside the block.

Optional Feature:
- Macro: VIDEO_LPEN_EN.
- Defined: lpen_strobe is synchronised with 2 flops, then its rising edge latches:
  - lpen_x = de ? {~hc[7],hc[6:0]} : 0
  - lpen_y = (vc>=ACTIVE_LINES) ? ACTIVE_LINES : vc[7:0]
- Undefined: no latch logic; lpen_x=lpen_y=0 constant and lpen_strobe is ignored.

Decomposition:
- Package video_pkg:
  - default timing constants;
  - cfg address constants (CFG_PEND_CLR=4'd15);
  - typedef for the NCMP-wide compare array.
- Sub-module video_int_ch, instantiated NCMP times. It holds one compare register, its int level and its pending bit. The frame channel reuses it with a hard-wired compare.

Test Plan:
- Free run with defaults -> hc 383->0 and vc 311->0 on the same ce; flash toggles every 16 frames (32-frame period).
- Write cmp0=100 -> int_line[0] high for exactly 128 ce at vc=100; int_pend[0]=1 afterwards; write addr15 data 8'h01 -> int_pend[0]=0.
- Write cmp1=200 (>=192) -> int_line[1] never asserts over 2 frames.
- Clear int_pend[NCMP] in the same clk as the frame-int rising edge -> pending remains 1.
- Assert nRESET low at vc=150, hc=200 -> all outputs return to reset values immediately without a clock; counting resumes from 0 after release.
- With VIDEO_LPEN_EN: pulse lpen_strobe at vc=50, hc=160 (de=1) -> lpen_y=50, lpen_x=8'h20+sync offset as computed from the hc at latch. Pulse at vc=250 -> lpen_y=192. Without the macro both outputs stay 0.
